// File: rtl/io_arb_pkg.sv
// Shared types and constants for the two-master I/O bus arbiter.
package io_arb_pkg;

  // Arbiter FSM: bus idle, transaction on the bus, completion pulse to owner.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } io_arb_state_t;

  // Master indices.
  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

endpackage

// File: rtl/io_arb_pick.sv
// Winner selection for the I/O bus arbiter.
// IO_ARB_ROUND_ROBIN_EN: when defined, ties go to the master that did not own the bus last;
// otherwise m0 always wins ties and no last-owner input exists.
module io_arb_pick
  import io_arb_pkg::*;
(
  input  logic i_m0_req,
  input  logic i_m1_req,
`ifdef IO_ARB_ROUND_ROBIN_EN
  input  logic i_last,
`endif
  output logic o_winner
);

  // A lone requester always wins; only a tie consults the policy.
  always_comb begin
    o_winner = M0;
    if (i_m0_req && i_m1_req) begin
`ifdef IO_ARB_ROUND_ROBIN_EN
      o_winner = (i_last == M0) ? M1 : M0;
`else
      o_winner = M0;
`endif
    end else if (i_m1_req) begin
      o_winner = M1;
    end
  end

endmodule

// File: rtl/io_bus_arbiter.sv
// Two-master arbiter for the 16-bit basic I/O register bus, with locked bursts of up to
// MAX_BURST transactions. Tie-break policy selected by IO_ARB_ROUND_ROBIN_EN (see io_arb_pick).
module io_bus_arbiter
  import io_arb_pkg::*;
#(
  parameter int unsigned MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m1_req,
  input  logic        m0_lock,
  input  logic        m1_lock,
  input  logic [15:0] m0_addr,
  input  logic [15:0] m1_addr,
  input  logic [15:0] m0_wdata,
  input  logic [15:0] m1_wdata,
  input  logic        m0_we,
  input  logic        m1_we,
  output logic        m0_gnt,
  output logic        m1_gnt,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic [15:0] m0_rdata,
  output logic [15:0] m1_rdata,
  output logic [15:0] addr,
  output logic [15:0] data_in,
  input  logic [15:0] data_out,
  output logic        we
);

  localparam int unsigned CntW = $clog2(MAX_BURST) + 1;
  localparam logic [CntW-1:0] BurstLast = CntW'(MAX_BURST - 1);

  io_arb_state_t   r_state, w_state_nxt;
  logic            r_owner;
  logic [15:0]     r_addr, r_wdata;
  logic            r_we;
  logic [CntW-1:0] r_burst_cnt;
  logic            r_gnt0, r_gnt1, r_ack0, r_ack1;
  logic [15:0]     r_rdata0, r_rdata1;

  logic            w_winner, w_start, w_cont, w_release;
  logic            w_own_req, w_own_lock, w_cap_sel;
  logic [15:0]     w_cap_addr, w_cap_wdata;
  logic            w_cap_we;

`ifdef IO_ARB_ROUND_ROBIN_EN
  logic r_last;

  // Remember the most recent owner so the next tie goes the other way.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= M1;
    end else if (w_start) begin
      r_last <= w_winner;
    end
  end
`endif

  io_arb_pick u_pick (
    .i_m0_req (m0_req),
    .i_m1_req (m1_req),
`ifdef IO_ARB_ROUND_ROBIN_EN
    .i_last   (r_last),
`endif
    .o_winner (w_winner)
  );

  assign w_own_req  = (r_owner == M1) ? m1_req  : m0_req;
  assign w_own_lock = (r_owner == M1) ? m1_lock : m0_lock;

  // New grant captures the winner; a locked continuation recaptures the current owner.
  assign w_cap_sel   = w_start ? w_winner : r_owner;
  assign w_cap_addr  = (w_cap_sel == M1) ? m1_addr  : m0_addr;
  assign w_cap_wdata = (w_cap_sel == M1) ? m1_wdata : m0_wdata;
  assign w_cap_we    = (w_cap_sel == M1) ? m1_we    : m0_we;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and transition events.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_cont      = 1'b0;
    w_release   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (m0_req || m1_req) begin
          w_state_nxt = ISSUE;
          w_start     = 1'b1;
        end
      end
      ISSUE: w_state_nxt = DONE;
      DONE: begin
        if (w_own_lock && w_own_req && (r_burst_cnt < BurstLast)) begin
          w_state_nxt = ISSUE;
          w_cont      = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Capture registers, owner, burst counter and grants.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr      <= '0;
      r_wdata     <= '0;
      r_we        <= 1'b0;
      r_owner     <= M0;
      r_burst_cnt <= '0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
    end else begin
      if (w_start || w_cont) begin
        r_addr  <= w_cap_addr;
        r_wdata <= w_cap_wdata;
        r_we    <= w_cap_we;
      end
      if (w_start) begin
        r_owner     <= w_winner;
        r_burst_cnt <= '0;
        r_gnt0      <= (w_winner == M0);
        r_gnt1      <= (w_winner == M1);
      end else if (w_cont) begin
        // Only taken below BurstLast, so the counter saturates rather than wraps.
        r_burst_cnt <= r_burst_cnt + CntW'(1);
      end else if (w_release) begin
        r_gnt0 <= 1'b0;
        r_gnt1 <= 1'b0;
      end
    end
  end

  // Ack pulse and read data for the owner during DONE; zero at all other times.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else if (r_state == ISSUE) begin
      r_ack0   <= (r_owner == M0);
      r_ack1   <= (r_owner == M1);
      r_rdata0 <= (r_owner == M0) ? data_out : 16'h0;
      r_rdata1 <= (r_owner == M1) ? data_out : 16'h0;
    end else begin
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end
  end

  assign m0_gnt   = r_gnt0;
  assign m1_gnt   = r_gnt1;
  assign m0_ack   = r_ack0;
  assign m1_ack   = r_ack1;
  assign m0_rdata = r_rdata0;
  assign m1_rdata = r_rdata1;

  // Bus is driven only in ISSUE, so a reset drops it immediately.
  assign addr    = (r_state == ISSUE) ? r_addr  : 16'h0;
  assign data_in = (r_state == ISSUE) ? r_wdata : 16'h0;
  assign we      = (r_state == ISSUE) && r_we;

endmodule
